// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states and the store queue entry.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LD_WAIT,
    ST_WAIT
  } dmem_arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } store_entry_t;

endpackage

// File: rtl/dmem_arbiter_store_fifo.sv
// Circular buffer of committed stores with a per-entry word-address match vector
// used to hold back loads that would read ahead of an older store.
module store_fifo
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  store_entry_t           push_entry,
  input  logic                   pop,
  output store_entry_t           head_entry,
  output logic [$clog2(DEPTH):0] count,
  input  logic [29:0]            match_word,
  output logic [DEPTH-1:0]       match_vec
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  store_entry_t     mem    [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] offset [DEPTH];

  assign head_entry = mem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_entry;
  end

  // An entry is live when its distance from head (mod DEPTH) is below count.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset[i]    = PTR_W'(i) - head;
      match_vec[i] = ({1'b0, offset[i]} < count) && (mem[i].addr[31:2] == match_word);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-owner data-memory port arbiter: speculative loads vs committed stores,
// one outstanding transaction, load-after-store ordering and store anti-starvation.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned STQ_DEPTH    = 4,
  parameter int unsigned ROB_IDX_W    = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 ld_req_valid,
  output logic                 ld_req_ready,
  input  logic [31:0]          ld_req_addr,
  input  logic [3:0]           ld_req_rmask,
  input  logic [ROB_IDX_W-1:0] ld_req_tag,
  output logic                 ld_resp_valid,
  output logic [31:0]          ld_resp_rdata,
  output logic [ROB_IDX_W-1:0] ld_resp_tag,
  input  logic                 st_valid,
  output logic                 st_ready,
  input  logic [31:0]          st_addr,
  input  logic [3:0]           st_wmask,
  input  logic [31:0]          st_wdata,
  output logic                 stq_empty,
  output logic [31:0]          dmem_addr,
  output logic [3:0]           dmem_rmask,
  output logic [3:0]           dmem_wmask,
  output logic [31:0]          dmem_wdata,
  input  logic [31:0]          dmem_rdata,
  input  logic                 dmem_resp
);

  localparam int unsigned CNT_W = $clog2(STQ_DEPTH) + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  dmem_arb_state_t      state;
  store_entry_t         push_entry;
  store_entry_t         head_entry;
  logic [CNT_W-1:0]     count;
  logic [STQ_DEPTH-1:0] match_vec;
  logic [STV_W-1:0]     starve;
  logic [ROB_IDX_W-1:0] tag_q;
  logic                 squash;
  logic                 push;
  logic                 pop;
  logic                 conflict;
  logic                 force_store;
  logic                 sel_load;
  logic                 sel_store;

  assign push_entry = '{addr: st_addr, wmask: st_wmask, wdata: st_wdata};
  assign st_ready   = count < CNT_W'(STQ_DEPTH);
  assign stq_empty  = (count == '0);
  assign push       = st_valid && st_ready;
  assign pop        = (state == ST_WAIT) && dmem_resp;
  assign conflict   = |match_vec;
  assign force_store = (count == CNT_W'(STQ_DEPTH)) || (starve >= STV_W'(STARVE_LIMIT));

  store_fifo #(
    .DEPTH(STQ_DEPTH)
  ) u_stq (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .head_entry(head_entry),
    .count     (count),
    .match_word(ld_req_addr[31:2]),
    .match_vec (match_vec)
  );

  // A conflict always implies a non-empty queue, so the remaining store cases collapse to count != 0.
  always_comb begin
    sel_load  = 1'b0;
    sel_store = 1'b0;
    if (state == IDLE && !rst) begin
      if (!force_store && ld_req_valid && !flush && !conflict)
        sel_load = 1'b1;
      else if (count != '0)
        sel_store = 1'b1;
    end
  end

  assign ld_req_ready = sel_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      starve        <= '0;
      tag_q         <= '0;
      squash        <= 1'b0;
      ld_resp_valid <= 1'b0;
      ld_resp_rdata <= '0;
      ld_resp_tag   <= '0;
      dmem_addr     <= '0;
      dmem_rmask    <= '0;
      dmem_wmask    <= '0;
      dmem_wdata    <= '0;
    end else begin
      ld_resp_valid <= 1'b0;

      if (count == '0 || sel_store)
        starve <= '0;
      else if (sel_load)
        starve <= starve + 1'b1;

      case (state)
        IDLE: begin
          if (sel_load) begin
            dmem_addr  <= ld_req_addr;
            dmem_rmask <= ld_req_rmask;
            dmem_wmask <= '0;
            dmem_wdata <= '0;
            tag_q      <= ld_req_tag;
            state      <= LD_WAIT;
          end else if (sel_store) begin
            dmem_addr  <= head_entry.addr;
            dmem_rmask <= '0;
            dmem_wmask <= head_entry.wmask;
            dmem_wdata <= head_entry.wdata;
            state      <= ST_WAIT;
          end
        end
        LD_WAIT: begin
          squash <= squash | flush;
          if (dmem_resp) begin
            ld_resp_valid <= !(squash || flush);
            ld_resp_rdata <= dmem_rdata;
            ld_resp_tag   <= tag_q;
            squash        <= 1'b0;
            dmem_addr     <= '0;
            dmem_rmask    <= '0;
            dmem_wmask    <= '0;
            dmem_wdata    <= '0;
            state         <= IDLE;
          end
        end
        ST_WAIT: begin
          if (dmem_resp) begin
            dmem_addr  <= '0;
            dmem_rmask <= '0;
            dmem_wmask <= '0;
            dmem_wdata <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_dmem_arbiter;

  localparam int DEPTH = 4;
  localparam int TW    = 4;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          ld_req_valid;
  logic          ld_req_ready;
  logic [31:0]   ld_req_addr;
  logic [3:0]    ld_req_rmask;
  logic [TW-1:0] ld_req_tag;
  logic          ld_resp_valid;
  logic [31:0]   ld_resp_rdata;
  logic [TW-1:0] ld_resp_tag;
  logic          st_valid;
  logic          st_ready;
  logic [31:0]   st_addr;
  logic [3:0]    st_wmask;
  logic [31:0]   st_wdata;
  logic          stq_empty;
  logic [31:0]   dmem_addr;
  logic [3:0]    dmem_rmask;
  logic [3:0]    dmem_wmask;
  logic [31:0]   dmem_wdata;
  logic [31:0]   dmem_rdata;
  logic          dmem_resp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .STQ_DEPTH   (DEPTH),
    .ROB_IDX_W   (TW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .ld_req_valid (ld_req_valid),
    .ld_req_ready (ld_req_ready),
    .ld_req_addr  (ld_req_addr),
    .ld_req_rmask (ld_req_rmask),
    .ld_req_tag   (ld_req_tag),
    .ld_resp_valid(ld_resp_valid),
    .ld_resp_rdata(ld_resp_rdata),
    .ld_resp_tag  (ld_resp_tag),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_wmask     (st_wmask),
    .st_wdata     (st_wdata),
    .stq_empty    (stq_empty),
    .dmem_addr    (dmem_addr),
    .dmem_rmask   (dmem_rmask),
    .dmem_wmask   (dmem_wmask),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp)
  );

  // Reference model state: queued stores plus the single outstanding transaction (kind 0 = none, 1 = load, 2 = store).
  typedef struct {
    logic [31:0] a;
    logic [3:0]  m;
    logic [31:0] d;
  } st_t;

  st_t           q[$];
  int            m_kind;
  int            m_starve;
  bit            m_sq;
  logic [31:0]   m_addr;
  logic [3:0]    m_rmask;
  logic [3:0]    m_wmask;
  logic [31:0]   m_wdata;
  logic [TW-1:0] m_tag;
  bit            m_rv;
  logic [31:0]   m_rd;
  logic [TW-1:0] m_rt;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    flush = 0; ld_req_valid = 0; ld_req_addr = '0; ld_req_rmask = '0; ld_req_tag = '0;
    st_valid = 0; st_addr = '0; st_wmask = '0; st_wdata = '0; dmem_rdata = '0; dmem_resp = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    idle_inputs();
    tick();
    tick();
    rst = 0;
  endtask

  task automatic set_load(input logic [31:0] a, input logic [3:0] m, input logic [TW-1:0] t);
    ld_req_valid = 1; ld_req_addr = a; ld_req_rmask = m; ld_req_tag = t;
  endtask

  task automatic set_store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    st_valid = 1; st_addr = a; st_wmask = m; st_wdata = d;
  endtask

  task automatic test_reset;
    rst = 1;
    idle_inputs();
    dmem_resp = 1;
    tick();
    tick();
    total++; if (dmem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", dmem_addr); end
    total++; if (dmem_rmask !== 4'h0 || dmem_wmask !== 4'h0) begin bad++; $display("FAIL rst_masks got=%h/%h exp=0/0", dmem_rmask, dmem_wmask); end
    total++; if (dmem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", dmem_wdata); end
    total++; if (ld_resp_valid !== 1'b0 || ld_resp_rdata !== 32'h0 || ld_resp_tag !== '0) begin bad++; $display("FAIL rst_resp got=%b/%h/%h exp=0/0/0", ld_resp_valid, ld_resp_rdata, ld_resp_tag); end
    total++; if (stq_empty !== 1'b1 || st_ready !== 1'b1) begin bad++; $display("FAIL rst_stq got=%b/%b exp=1/1", stq_empty, st_ready); end
    set_load(32'h40, 4'hF, 4'd1);
    #1;
    total++; if (ld_req_ready !== 1'b0) begin bad++; $display("FAIL rst_no_accept got=%b exp=0", ld_req_ready); end
    tick();
    total++; if (dmem_rmask !== 4'h0) begin bad++; $display("FAIL rst_no_issue got=%h exp=0", dmem_rmask); end
    rst = 0;
    idle_inputs();
    tick();
  endtask

  task automatic test_load_basic;
    do_reset();
    set_load(32'h0000_1000, 4'hF, 4'd3);
    #1;
    total++; if (ld_req_ready !== 1'b1) begin bad++; $display("FAIL ld_ready got=%b exp=1", ld_req_ready); end
    tick();
    ld_req_valid = 0;
    total++; if (dmem_addr !== 32'h1000 || dmem_rmask !== 4'hF || dmem_wmask !== 4'h0) begin bad++; $display("FAIL ld_issue got=%h/%h/%h exp=1000/f/0", dmem_addr, dmem_rmask, dmem_wmask); end
    tick();
    total++; if (dmem_addr !== 32'h1000 || dmem_rmask !== 4'hF) begin bad++; $display("FAIL ld_hold got=%h/%h exp=1000/f", dmem_addr, dmem_rmask); end
    dmem_resp = 1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_resp = 0;
    total++; if (ld_resp_valid !== 1'b1 || ld_resp_tag !== 4'd3 || ld_resp_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ld_resp got=%b/%h/%h exp=1/3/deadbeef", ld_resp_valid, ld_resp_tag, ld_resp_rdata); end
    total++; if (dmem_addr !== 32'h0 || dmem_rmask !== 4'h0) begin bad++; $display("FAIL ld_clear got=%h/%h exp=0/0", dmem_addr, dmem_rmask); end
    tick();
    total++; if (ld_resp_valid !== 1'b0) begin bad++; $display("FAIL ld_pulse got=%b exp=0", ld_resp_valid); end
  endtask

  task automatic test_full_force;
    do_reset();
    set_load(32'h500, 4'hF, 4'd2);
    tick();
    ld_req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      set_store(32'h100 + 32'(i * 4), 4'hF, 32'hA0 + 32'(i));
      tick();
    end
    st_valid = 0;
    total++; if (st_ready !== 1'b0 || stq_empty !== 1'b0) begin bad++; $display("FAIL full_ready got=%b/%b exp=0/0", st_ready, stq_empty); end
    dmem_resp = 1;
    tick();
    dmem_resp = 0;
    set_load(32'h900, 4'hF, 4'd1);
    #1;
    total++; if (ld_req_ready !== 1'b0) begin bad++; $display("FAIL full_ld_block got=%b exp=0", ld_req_ready); end
    tick();
    ld_req_valid = 0;
    total++; if (dmem_addr !== 32'h100 || dmem_wmask !== 4'hF || dmem_rmask !== 4'h0 || dmem_wdata !== 32'hA0) begin bad++; $display("FAIL full_force got=%h/%h/%h/%h exp=100/f/0/a0", dmem_addr, dmem_wmask, dmem_rmask, dmem_wdata); end
  endtask

  // Continues from test_full_force: queue full, head store 0x100 in flight.
  task automatic test_wrap;
    int n;
    set_store(32'h110, 4'hF, 32'hB0);
    dmem_resp = 1;
    #1;
    total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL wrap_nobypass got=%b exp=0", st_ready); end
    tick();
    dmem_resp = 0;
    total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL wrap_ready_rise got=%b exp=1", st_ready); end
    tick();
    st_valid = 0;
    total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL wrap_refill got=%b exp=0", st_ready); end
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (dmem_wmask == 4'h0 && n < 10) begin tick(); n++; end
      total++; if (dmem_addr !== 32'h104 + 32'(k * 4)) begin bad++; $display("FAIL wrap_order%0d got=%h exp=%h", k, dmem_addr, 32'h104 + 32'(k * 4)); end
      dmem_resp = 1;
      tick();
      dmem_resp = 0;
    end
    total++; if (stq_empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", stq_empty); end
  endtask

  task automatic test_conflict;
    do_reset();
    set_store(32'h2004, 4'h3, 32'h0000_5566);
    tick();
    st_valid = 0;
    set_load(32'h2008, 4'hF, 4'd2);
    #1;
    total++; if (ld_req_ready !== 1'b1) begin bad++; $display("FAIL cf_noconf_ready got=%b exp=1", ld_req_ready); end
    tick();
    ld_req_valid = 0;
    total++; if (dmem_addr !== 32'h2008 || dmem_rmask !== 4'hF) begin bad++; $display("FAIL cf_noconf_issue got=%h/%h exp=2008/f", dmem_addr, dmem_rmask); end
    dmem_resp = 1;
    tick();
    dmem_resp = 0;
    set_load(32'h2004, 4'hC, 4'd4);
    #1;
    total++; if (ld_req_ready !== 1'b0) begin bad++; $display("FAIL cf_block got=%b exp=0", ld_req_ready); end
    tick();
    total++; if (dmem_addr !== 32'h2004 || dmem_wmask !== 4'h3 || dmem_wdata !== 32'h5566 || dmem_rmask !== 4'h0) begin bad++; $display("FAIL cf_store_first got=%h/%h/%h/%h exp=2004/3/5566/0", dmem_addr, dmem_wmask, dmem_wdata, dmem_rmask); end
    #1;
    total++; if (ld_req_ready !== 1'b0) begin bad++; $display("FAIL cf_wait_block got=%b exp=0", ld_req_ready); end
    dmem_resp = 1;
    tick();
    dmem_resp = 0;
    #1;
    total++; if (ld_req_ready !== 1'b1 || stq_empty !== 1'b1) begin bad++; $display("FAIL cf_after_pop got=%b/%b exp=1/1", ld_req_ready, stq_empty); end
    tick();
    ld_req_valid = 0;
    total++; if (dmem_addr !== 32'h2004 || dmem_rmask !== 4'hC || dmem_wmask !== 4'h0) begin bad++; $display("FAIL cf_load_issue got=%h/%h/%h exp=2004/c/0", dmem_addr, dmem_rmask, dmem_wmask); end
    dmem_resp = 1;
    tick();
    dmem_resp = 0;
    total++; if (ld_resp_valid !== 1'b1 || ld_resp_tag !== 4'd4) begin bad++; $display("FAIL cf_load_resp got=%b/%h exp=1/4", ld_resp_valid, ld_resp_tag); end
  endtask

  task automatic test_starve;
    int loads;
    int n;
    do_reset();
    set_store(32'h3000, 4'hF, 32'h33);
    tick();
    st_valid = 0;
    set_load(32'h4000, 4'hF, 4'd5);
    dmem_resp = 1;
    loads = 0;
    n = 0;
    while (dmem_wmask == 4'h0 && n < 40) begin
      tick();
      n++;
      if (dmem_rmask != 4'h0) loads++;
    end
    total++; if (dmem_wmask === 4'h0) begin bad++; $display("FAIL starve_timeout got=none exp=store"); end
    total++; if (loads !== LIMIT) begin bad++; $display("FAIL starve_loads got=%0d exp=%0d", loads, LIMIT); end
    total++; if (dmem_addr !== 32'h3000) begin bad++; $display("FAIL starve_store got=%h exp=3000", dmem_addr); end
    set_store(32'h3100, 4'hF, 32'h31);
    tick();
    st_valid = 0;
    #1;
    total++; if (ld_req_ready !== 1'b1) begin bad++; $display("FAIL starve_reset got=%b exp=1", ld_req_ready); end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush;
    do_reset();
    set_load(32'h6000, 4'hF, 4'd6);
    set_store(32'h5000, 4'hF, 32'h55);
    #1;
    total++; if (ld_req_ready !== 1'b1) begin bad++; $display("FAIL fl_accept got=%b exp=1", ld_req_ready); end
    tick();
    ld_req_valid = 0; st_valid = 0;
    flush = 1;
    tick();
    flush = 0;
    dmem_resp = 1; dmem_rdata = 32'h1234;
    tick();
    dmem_resp = 0;
    total++; if (ld_resp_valid !== 1'b0) begin bad++; $display("FAIL fl_squash got=%b exp=0", ld_resp_valid); end
    total++; if (stq_empty !== 1'b0 || st_ready !== 1'b1) begin bad++; $display("FAIL fl_fifo got=%b/%b exp=0/1", stq_empty, st_ready); end
    tick();
    total++; if (dmem_addr !== 32'h5000 || dmem_wmask !== 4'hF || dmem_wdata !== 32'h55) begin bad++; $display("FAIL fl_store_kept got=%h/%h/%h exp=5000/f/55", dmem_addr, dmem_wmask, dmem_wdata); end
    dmem_resp = 1;
    tick();
    dmem_resp = 0;
    set_load(32'h6000, 4'hF, 4'd7);
    #1;
    total++; if (ld_req_ready !== 1'b1) begin bad++; $display("FAIL fl_next_accept got=%b exp=1", ld_req_ready); end
    tick();
    ld_req_valid = 0;
    dmem_resp = 1; dmem_rdata = 32'h7777;
    tick();
    dmem_resp = 0;
    total++; if (ld_resp_valid !== 1'b1 || ld_resp_tag !== 4'd7 || ld_resp_rdata !== 32'h7777) begin bad++; $display("FAIL fl_next_resp got=%b/%h/%h exp=1/7/7777", ld_resp_valid, ld_resp_tag, ld_resp_rdata); end
  endtask

  // Arbitration decision straight from the priority rules, using a linear queue search for conflicts.
  task automatic model_pick(output bit pl, output bit ps);
    bit conf;
    bit forced;
    pl = 0;
    ps = 0;
    conf = 0;
    foreach (q[i]) if (q[i].a[31:2] == ld_req_addr[31:2]) conf = 1;
    forced = (q.size() == DEPTH) || (m_starve >= LIMIT);
    if (rst || m_kind != 0) return;
    if (forced) ps = 1;
    else if (ld_req_valid && !flush && !conf) pl = 1;
    else if (ld_req_valid && conf) ps = 1;
    else if (q.size() > 0) ps = 1;
  endtask

  task automatic model_step;
    bit pl;
    bit ps;
    bit push;
    model_pick(pl, ps);
    push = st_valid && (q.size() < DEPTH);
    if (rst) begin
      q.delete(); m_kind = 0; m_sq = 0; m_starve = 0; m_rv = 0; m_rd = '0; m_rt = '0;
      return;
    end
    m_rv = 0;
    if (q.size() == 0 || ps) m_starve = 0;
    else if (pl) m_starve++;
    if (m_kind == 0) begin
      if (pl) begin
        m_kind = 1; m_addr = ld_req_addr; m_rmask = ld_req_rmask; m_wmask = '0; m_wdata = '0; m_tag = ld_req_tag;
      end else if (ps) begin
        m_kind = 2; m_addr = q[0].a; m_rmask = '0; m_wmask = q[0].m; m_wdata = q[0].d;
      end
    end else if (m_kind == 1) begin
      if (flush) m_sq = 1;
      if (dmem_resp) begin
        m_rv = !m_sq; m_rd = dmem_rdata; m_rt = m_tag; m_kind = 0; m_sq = 0;
      end
    end else if (dmem_resp) begin
      void'(q.pop_front());
      m_kind = 0;
    end
    if (push) q.push_back('{st_addr, st_wmask, st_wdata});
  endtask

  task automatic test_random;
    bit pl;
    bit ps;
    logic [31:0] e_addr;
    logic [3:0]  e_rm;
    logic [3:0]  e_wm;
    logic [31:0] e_wd;
    do_reset();
    q.delete(); m_kind = 0; m_sq = 0; m_starve = 0; m_rv = 0; m_rd = '0; m_rt = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst          = ($urandom_range(0, 199) == 0);
      ld_req_valid = $urandom_range(0, 1) == 1;
      ld_req_addr  = 32'h8000 + ($urandom_range(0, 7) << 2);
      ld_req_rmask = 4'($urandom_range(1, 15));
      ld_req_tag   = TW'($urandom);
      st_valid     = ($urandom_range(0, 2) == 0);
      st_addr      = 32'h8000 + ($urandom_range(0, 7) << 2);
      st_wmask     = 4'($urandom_range(1, 15));
      st_wdata     = $urandom;
      flush        = ($urandom_range(0, 9) == 0);
      dmem_resp    = ($urandom_range(0, 2) == 0);
      dmem_rdata   = $urandom;
      #1;
      model_pick(pl, ps);
      e_addr = (m_kind != 0) ? m_addr  : 32'h0;
      e_rm   = (m_kind != 0) ? m_rmask : 4'h0;
      e_wm   = (m_kind != 0) ? m_wmask : 4'h0;
      e_wd   = (m_kind != 0) ? m_wdata : 32'h0;
      total++; if (ld_req_ready !== pl) begin bad++; $display("FAIL rnd_ld_ready c=%0d got=%b exp=%b", cyc, ld_req_ready, pl); end
      total++; if (st_ready !== (q.size() < DEPTH)) begin bad++; $display("FAIL rnd_st_ready c=%0d got=%b exp=%b", cyc, st_ready, q.size() < DEPTH); end
      total++; if (stq_empty !== (q.size() == 0)) begin bad++; $display("FAIL rnd_empty c=%0d got=%b exp=%b", cyc, stq_empty, q.size() == 0); end
      total++; if (dmem_addr !== e_addr) begin bad++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", cyc, dmem_addr, e_addr); end
      total++; if (dmem_rmask !== e_rm || dmem_wmask !== e_wm) begin bad++; $display("FAIL rnd_masks c=%0d got=%h/%h exp=%h/%h", cyc, dmem_rmask, dmem_wmask, e_rm, e_wm); end
      total++; if (dmem_wdata !== e_wd) begin bad++; $display("FAIL rnd_wdata c=%0d got=%h exp=%h", cyc, dmem_wdata, e_wd); end
      total++; if (ld_resp_valid !== m_rv) begin bad++; $display("FAIL rnd_resp_valid c=%0d got=%b exp=%b", cyc, ld_resp_valid, m_rv); end
      if (m_rv) begin
        total++; if (ld_resp_rdata !== m_rd || ld_resp_tag !== m_rt) begin bad++; $display("FAIL rnd_resp_data c=%0d got=%h/%h exp=%h/%h", cyc, ld_resp_rdata, ld_resp_tag, m_rd, m_rt); end
      end
      model_step();
      @(posedge clk);
      #1;
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_load_basic();
    test_full_force();
    test_wrap();
    test_conflict();
    test_starve();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
